// File: rtl/dbg_guv_rb.sv
// dbg_guv_rb: inline AXI-Stream debug governor with pause/drop/log/inject
// controls, a daisy-chained command bus and a two-flit statistics readback.
module dbg_guv_rb #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 16,
    parameter int CNT_SIZE   = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int ADDR       = 0,
    parameter int PIPE_STAGE = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            cmd_in_TDATA,
    input  logic                             cmd_in_TVALID,
    output logic [DATA_WIDTH-1:0]            cmd_out_TDATA,
    output logic                             cmd_out_TVALID,
    input  logic [DATA_WIDTH-1:0]            in_TDATA,
    input  logic                             in_TVALID,
    output logic                             in_TREADY,
    input  logic                             in_TLAST,
    input  logic [DEST_WIDTH-1:0]            in_TDEST,
    output logic [DATA_WIDTH-1:0]            out_TDATA,
    output logic                             out_TVALID,
    input  logic                             out_TREADY,
    output logic                             out_TLAST,
    output logic [DEST_WIDTH-1:0]            out_TDEST,
    output logic [DATA_WIDTH+DEST_WIDTH:0]   log_TDATA,
    output logic                             log_TVALID,
    input  logic                             log_TREADY,
    output logic [DATA_WIDTH-1:0]            rsp_TDATA,
    output logic                             rsp_TVALID,
    input  logic                             rsp_TREADY,
    output logic                             rsp_TLAST
);
    localparam logic [ADDR_WIDTH-1:0] MY_ADDR = ADDR_WIDTH'(ADDR);
    localparam logic [CNT_SIZE-1:0]   CNT_ONE = CNT_SIZE'(1);

    typedef enum logic {S_ADDR, S_DATA} cmd_st_e;

    cmd_st_e st_q, st_d;
    logic [3:0] reg_q, reg_d;
    logic       wr_en, commit, rb_req;

    logic [3:0]            cmd_reg;
    logic [ADDR_WIDTH-1:0] cmd_core;
    logic                  cmd_hit;

    // shadow (staged) controls
    logic [CNT_SIZE-1:0]   drop_sh_q, log_sh_q;
    logic [DATA_WIDTH-1:0] inj_data_sh_q;
    logic                  inj_vld_sh_q, inj_last_sh_q;
    logic [DEST_WIDTH-1:0] inj_dest_sh_q;
    logic                  kp_sh_q, kl_sh_q, kd_sh_q;

    // live controls
    logic [CNT_SIZE-1:0]   drop_q, lcnt_q;
    logic [DATA_WIDTH-1:0] inj_data_q;
    logic                  inj_vld_q, inj_last_q;
    logic [DEST_WIDTH-1:0] inj_dest_q;
    logic                  kp_q, kl_q, kd_q;

    logic mid_q;

    // statistics and readback
    logic [CNT_SIZE-1:0] pass_cnt_q, pass_cnt_d, drop_tot_q, drop_tot_d, snap_q;
    logic                rsp_vld_q, rsp_idx_q, ovr_q;

    logic pause, drop_en, log_en, inj_act;
    logic in_fire, pass_fire, drop_fire, log_fire, inj_fire, rsp_done;

    assign cmd_reg  = cmd_in_TDATA[3:0];
    assign cmd_core = cmd_in_TDATA[ADDR_WIDTH+3:4];
    assign cmd_hit  = cmd_in_TVALID && (cmd_core == MY_ADDR);

    // daisy-chain copy of the command bus, optionally registered
    generate
        if (PIPE_STAGE != 0) begin : g_cmd_pipe
            logic [DATA_WIDTH-1:0] cmd_data_q;
            logic                  cmd_vld_q;
            // one-cycle echo of the command bus
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cmd_data_q <= '0;
                    cmd_vld_q  <= 1'b0;
                end else begin
                    cmd_data_q <= cmd_in_TDATA;
                    cmd_vld_q  <= cmd_in_TVALID;
                end
            end
            assign cmd_out_TDATA  = cmd_data_q;
            assign cmd_out_TVALID = cmd_vld_q;
        end else begin : g_cmd_comb
            assign cmd_out_TDATA  = cmd_in_TDATA;
            assign cmd_out_TVALID = cmd_in_TVALID;
        end
    endgenerate

    // command FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q  <= S_ADDR;
            reg_q <= '0;
        end else begin
            st_q  <= st_d;
            reg_q <= reg_d;
        end
    end

    // command FSM next state: register writes take an address flit then a data flit
    always_comb begin
        st_d   = st_q;
        reg_d  = reg_q;
        wr_en  = 1'b0;
        commit = 1'b0;
        rb_req = 1'b0;
        case (st_q)
            S_ADDR: begin
                if (cmd_hit) begin
                    if (cmd_reg <= 4'd8) begin
                        reg_d = cmd_reg;
                        st_d  = S_DATA;
                    end else if (cmd_reg == 4'd15) begin
                        commit = 1'b1;
                    end else if (cmd_reg == 4'd14) begin
                        rb_req = 1'b1;
                    end
                end
            end
            S_DATA: begin
                // data flit is taken regardless of its address bits
                if (cmd_in_TVALID) begin
                    wr_en = 1'b1;
                    st_d  = S_ADDR;
                end
            end
        endcase
    end

    // shadow registers: written by data flits, one-shots cleared on commit
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_sh_q     <= '0;
            log_sh_q      <= '0;
            inj_data_sh_q <= '0;
            inj_vld_sh_q  <= 1'b0;
            inj_last_sh_q <= 1'b0;
            inj_dest_sh_q <= '0;
            kp_sh_q       <= 1'b0;
            kl_sh_q       <= 1'b0;
            kd_sh_q       <= 1'b0;
        end else begin
            if (wr_en) begin
                case (reg_q)
                    4'd0: drop_sh_q     <= cmd_in_TDATA[CNT_SIZE-1:0];
                    4'd1: log_sh_q      <= cmd_in_TDATA[CNT_SIZE-1:0];
                    4'd2: inj_data_sh_q <= cmd_in_TDATA;
                    4'd3: inj_vld_sh_q  <= cmd_in_TDATA[0];
                    4'd4: inj_last_sh_q <= cmd_in_TDATA[0];
                    4'd5: inj_dest_sh_q <= cmd_in_TDATA[DEST_WIDTH-1:0];
                    4'd6: kp_sh_q       <= cmd_in_TDATA[0];
                    4'd7: kl_sh_q       <= cmd_in_TDATA[0];
                    4'd8: kd_sh_q       <= cmd_in_TDATA[0];
                    default: ;
                endcase
            end
            if (commit) begin
                drop_sh_q    <= '0;
                log_sh_q     <= '0;
                inj_vld_sh_q <= 1'b0;
            end
        end
    end

    // live registers: loaded on commit, otherwise consumed by traffic
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_q     <= '0;
            lcnt_q     <= '0;
            inj_data_q <= '0;
            inj_vld_q  <= 1'b0;
            inj_last_q <= 1'b0;
            inj_dest_q <= '0;
            kp_q       <= 1'b0;
            kl_q       <= 1'b0;
            kd_q       <= 1'b0;
        end else if (commit) begin
            drop_q     <= drop_sh_q;
            lcnt_q     <= log_sh_q;
            inj_data_q <= inj_data_sh_q;
            inj_vld_q  <= inj_vld_sh_q;
            inj_last_q <= inj_last_sh_q;
            inj_dest_q <= inj_dest_sh_q;
            kp_q       <= kp_sh_q;
            kl_q       <= kl_sh_q;
            kd_q       <= kd_sh_q;
        end else begin
            if (drop_fire && drop_q != '0) drop_q <= drop_q - CNT_ONE;
            if (log_fire && lcnt_q != '0)  lcnt_q <= lcnt_q - CNT_ONE;
            if (inj_fire)                  inj_vld_q <= 1'b0;
        end
    end

    assign pause   = kp_q && drop_q == '0 && lcnt_q == '0;
    assign drop_en = kd_q || drop_q != '0;
    assign log_en  = kl_q || lcnt_q != '0;
    assign inj_act = inj_vld_q && !mid_q;

    assign log_TDATA = {in_TLAST, in_TDEST, in_TDATA};

    // datapath steering: inject > pause > drop > pass
    always_comb begin
        out_TDATA  = in_TDATA;
        out_TLAST  = in_TLAST;
        out_TDEST  = in_TDEST;
        out_TVALID = 1'b0;
        in_TREADY  = 1'b0;
        log_TVALID = 1'b0;
        if (inj_act) begin
            out_TDATA  = inj_data_q;
            out_TLAST  = inj_last_q;
            out_TDEST  = inj_dest_q;
            out_TVALID = 1'b1;
        end else if (pause) begin
            // hold everything
        end else if (drop_en) begin
            in_TREADY  = log_en ? log_TREADY : 1'b1;
            log_TVALID = log_en && in_TVALID;
        end else begin
            // each side only sees valid when the other can also take the flit,
            // so no flit is ever duplicated on out or log
            out_TVALID = in_TVALID && (log_TREADY || !log_en);
            in_TREADY  = out_TREADY && (log_TREADY || !log_en);
            log_TVALID = log_en && in_TVALID && out_TREADY;
        end
    end

    assign in_fire   = in_TVALID && in_TREADY;
    assign drop_fire = in_fire && drop_en;
    assign pass_fire = in_fire && !drop_en;
    assign log_fire  = log_TVALID && log_TREADY;
    assign inj_fire  = inj_act && out_TREADY;
    assign rsp_done  = rsp_vld_q && rsp_idx_q && rsp_TREADY;

    // mid-packet flag keeps injections on packet boundaries
    always_ff @(posedge clk) begin
        if (!rst)         mid_q <= 1'b0;
        else if (in_fire) mid_q <= !in_TLAST;
    end

    // saturating statistics, restarted when the second readback flit is taken
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        drop_tot_d = drop_tot_q;
        if (rsp_done) begin
            pass_cnt_d = {{(CNT_SIZE-1){1'b0}}, pass_fire};
            drop_tot_d = {{(CNT_SIZE-1){1'b0}}, drop_fire};
        end else begin
            if (pass_fire && pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_ONE;
            if (drop_fire && drop_tot_q != '1) drop_tot_d = drop_tot_q + CNT_ONE;
        end
    end

    // statistics registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pass_cnt_q <= '0;
            drop_tot_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            drop_tot_q <= drop_tot_d;
        end
    end

    // readback sequencer: flit 0 holds a pass snapshot, flit 1 reads drops live
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_vld_q <= 1'b0;
            rsp_idx_q <= 1'b0;
            snap_q    <= '0;
            ovr_q     <= 1'b0;
        end else begin
            if (rb_req && !rsp_vld_q) begin
                rsp_vld_q <= 1'b1;
                rsp_idx_q <= 1'b0;
                snap_q    <= pass_cnt_d;
            end else if (rsp_vld_q && rsp_TREADY) begin
                if (rsp_idx_q) rsp_vld_q <= 1'b0;
                else           rsp_idx_q <= 1'b1;
            end
            // an overlapping request is dropped but remembered
            if (rb_req && rsp_vld_q) ovr_q <= 1'b1;
            else if (rsp_done)       ovr_q <= 1'b0;
        end
    end

    // response word formatting
    always_comb begin
        rsp_TDATA = '0;
        if (rsp_idx_q) begin
            rsp_TDATA[CNT_SIZE-1:0]   = drop_tot_q;
            rsp_TDATA[DATA_WIDTH-1]   = ovr_q;
        end else begin
            rsp_TDATA[CNT_SIZE-1:0]   = snap_q;
        end
    end

    assign rsp_TVALID = rsp_vld_q;
    assign rsp_TLAST  = rsp_idx_q;

endmodule
